// File: rtl/dp_exp_divide.sv
// Exponent and special-case path for the binary64 divider.
// Forms a - b + 1023 with the normalisation correction and saturation, behind a two-stage valid/ready pipeline.
module dp_exp_divide (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        a_sign,
    input  logic        b_sign,
    input  logic [10:0] a_exp,
    input  logic [10:0] b_exp,
    input  logic        a_man_nz,
    input  logic        b_man_nz,
    input  logic        sig_ge,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [10:0] exp_out,
    output logic        sign_out,
    output logic        is_nan,
    output logic        is_inf,
    output logic        is_zero,
    output logic        ovf,
    output logic        unf,
    output logic        dbz
);

    logic s1_valid, s1_adv, s2_adv;
    logic s1_sign, s1_nan, s1_inf, s1_zero, s1_dbz;
    logic signed [12:0] s1_e;

    logic a_zero, a_max, a_nan, a_inf, a_norm;
    logic b_zero, b_max, b_nan, b_inf;
    logic r_nan, r_inf, r_zero, r_dbz;
    logic signed [12:0] e_calc;

    logic [10:0] n_exp;
    logic        n_inf, n_zero, n_ovf, n_unf;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    always_comb begin
        a_zero = (a_exp == '0);
        a_max  = (a_exp == '1);
        a_nan  = a_max && a_man_nz;
        a_inf  = a_max && !a_man_nz;
        a_norm = !a_zero && !a_max;
        b_zero = (b_exp == '0);
        b_max  = (b_exp == '1);
        b_nan  = b_max && b_man_nz;
        b_inf  = b_max && !b_man_nz;

        r_nan  = a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf);
        r_inf  = !r_nan && (a_inf || b_zero);
        r_dbz  = r_inf && b_zero && a_norm;
        r_zero = !r_nan && !r_inf && (a_zero || b_inf);

        // Range -1023..3068 fits 13-bit two's complement without wrapping.
        e_calc = {2'b00, a_exp} - {2'b00, b_exp} + 13'd1023 - {12'd0, !sig_ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_nan   <= 1'b0;
            s1_inf   <= 1'b0;
            s1_zero  <= 1'b0;
            s1_dbz   <= 1'b0;
            s1_e     <= '0;
        end else begin
            if (s1_adv) s1_valid <= in_valid;
            if (s1_adv && in_valid) begin
                s1_sign <= a_sign ^ b_sign;
                s1_nan  <= r_nan;
                s1_inf  <= r_inf;
                s1_zero <= r_zero;
                s1_dbz  <= r_dbz;
                s1_e    <= e_calc;
            end
        end
    end

    always_comb begin
        n_exp  = '0;
        n_inf  = s1_inf;
        n_zero = s1_zero;
        n_ovf  = 1'b0;
        n_unf  = 1'b0;
        if (s1_nan || s1_inf) begin
            n_exp = '1;
        end else if (s1_zero) begin
            n_exp = '0;
        end else if (s1_e >= 13'sd2047) begin
            n_exp = '1;
            n_inf = 1'b1;
            n_ovf = 1'b1;
        end else if (s1_e <= 13'sd0) begin
            n_zero = 1'b1;
            n_unf  = 1'b1;
        end else begin
            n_exp = s1_e[10:0];
        end
    end

    // Output payload only loads on a real result so it reads zero until the first one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            exp_out   <= '0;
            sign_out  <= 1'b0;
            is_nan    <= 1'b0;
            is_inf    <= 1'b0;
            is_zero   <= 1'b0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            dbz       <= 1'b0;
        end else begin
            if (s2_adv) out_valid <= s1_valid;
            if (s2_adv && s1_valid) begin
                exp_out  <= n_exp;
                sign_out <= s1_sign;
                is_nan   <= s1_nan;
                is_inf   <= n_inf;
                is_zero  <= n_zero;
                ovf      <= n_ovf;
                unf      <= n_unf;
                dbz      <= s1_dbz;
            end
        end
    end

endmodule

// File: tb/tb_dp_exp_divide.sv
// Bench for dp_exp_divide: directed special/boundary cases, backpressure, mid-flight reset,
// and randomized traffic against a plain-arithmetic reference model.
module tb_dp_exp_divide;

    typedef struct packed {
        logic        a_sign;
        logic        b_sign;
        logic [10:0] a_exp;
        logic [10:0] b_exp;
        logic        a_man_nz;
        logic        b_man_nz;
        logic        sig_ge;
    } op_t;

    typedef logic [17:0] res_t; // {exp, sign, nan, inf, zero, ovf, unf, dbz}

    logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
    logic        a_sign, b_sign, a_man_nz, b_man_nz, sig_ge;
    logic [10:0] a_exp, b_exp, exp_out;
    logic        sign_out, is_nan, is_inf, is_zero, ovf, unf, dbz;
    res_t        obs;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    dp_exp_divide dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a_sign(a_sign), .b_sign(b_sign), .a_exp(a_exp), .b_exp(b_exp),
        .a_man_nz(a_man_nz), .b_man_nz(b_man_nz), .sig_ge(sig_ge),
        .out_valid(out_valid), .out_ready(out_ready), .exp_out(exp_out),
        .sign_out(sign_out), .is_nan(is_nan), .is_inf(is_inf), .is_zero(is_zero),
        .ovf(ovf), .unf(unf), .dbz(dbz)
    );

    assign obs = {exp_out, sign_out, is_nan, is_inf, is_zero, ovf, unf, dbz};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic op_t mkop(input int as, input int bs, input int ae, input int be,
                                 input int am, input int bm, input int ge);
        op_t o;
        o.a_sign = 1'(as); o.b_sign = 1'(bs);
        o.a_exp = 11'(ae); o.b_exp = 11'(be);
        o.a_man_nz = 1'(am); o.b_man_nz = 1'(bm); o.sig_ge = 1'(ge);
        return o;
    endfunction

    function automatic res_t rv(input int e, input int s, input int nan, input int inf,
                                input int zero, input int ov, input int un, input int dz);
        return {11'(e), 1'(s), 1'(nan), 1'(inf), 1'(zero), 1'(ov), 1'(un), 1'(dz)};
    endfunction

    function automatic res_t model(input op_t o);
        bit az, an, ai, bz, bn, bi, s;
        int e;
        az = (o.a_exp == 0);
        an = (o.a_exp == 2047) && o.a_man_nz;
        ai = (o.a_exp == 2047) && !o.a_man_nz;
        bz = (o.b_exp == 0);
        bn = (o.b_exp == 2047) && o.b_man_nz;
        bi = (o.b_exp == 2047) && !o.b_man_nz;
        s  = o.a_sign ^ o.b_sign;
        if (an || bn || (az && bz) || (ai && bi)) return rv(2047, s, 1, 0, 0, 0, 0, 0);
        if (ai || bz) return rv(2047, s, 0, 1, 0, 0, 0, (bz && !az && !ai) ? 1 : 0);
        if (az || bi) return rv(0, s, 0, 0, 1, 0, 0, 0);
        e = int'(o.a_exp) - int'(o.b_exp) + 1023 - (o.sig_ge ? 0 : 1);
        if (e >= 2047) return rv(2047, s, 0, 1, 0, 1, 0, 0);
        if (e <= 0) return rv(0, s, 0, 0, 1, 0, 1, 0);
        return rv(e, s, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic int rexp();
        case ($urandom_range(0, 5))
            0: return 0;
            1: return 2047;
            2: return int'($urandom_range(1, 40));
            3: return int'($urandom_range(2000, 2046));
            default: return int'($urandom_range(1, 2046));
        endcase
    endfunction

    function automatic op_t randop();
        return mkop(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), rexp(), rexp(),
                    int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 1)));
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply(input op_t o);
        a_sign = o.a_sign; b_sign = o.b_sign; a_exp = o.a_exp; b_exp = o.b_exp;
        a_man_nz = o.a_man_nz; b_man_nz = o.b_man_nz; sig_ge = o.sig_ge;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepted at edge N, presented with out_valid after edge N+1, transferred at edge N+2.
    task automatic directed(input string tag, input op_t o, input res_t exp);
        apply(o);
        in_valid = 1'b1;
        #1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        tick();
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check(tag, 32'(obs), 32'(exp));
        tick();
    endtask

    initial begin
        op_t  cur;
        res_t q[$];
        int   sent, recv;
        bit   holding, fire_in, fire_out;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        apply(mkop(0, 0, 0, 0, 0, 0, 0));
        #1;
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_payload", 32'(obs), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        check("post_reset_in_ready", 32'(in_ready), 32'd1);
        check("post_reset_valid", 32'(out_valid), 32'd0);
        check("post_reset_payload", 32'(obs), 32'd0);

        directed("one_by_one",  mkop(0, 1, 1023, 1023, 0, 0, 1), rv(1023, 1, 0, 0, 0, 0, 0, 0));
        directed("norm_corr",   mkop(0, 0, 1023, 1023, 0, 0, 0), rv(1022, 0, 0, 0, 0, 0, 0, 0));
        directed("ovf_big",     mkop(1, 0, 2046, 1, 0, 0, 1),    rv(2047, 1, 0, 1, 0, 1, 0, 0));
        directed("unf_small",   mkop(0, 0, 1, 2046, 0, 0, 1),    rv(0, 0, 0, 0, 1, 0, 1, 0));
        directed("max_normal",  mkop(1, 1, 1024, 1, 1, 1, 0),    rv(2045, 0, 0, 0, 0, 0, 0, 0));
        directed("ovf_edge",    mkop(0, 0, 1025, 1, 0, 0, 1),    rv(2047, 0, 0, 1, 0, 1, 0, 0));
        directed("min_normal",  mkop(0, 1, 1, 1023, 0, 0, 1),    rv(1, 1, 0, 0, 0, 0, 0, 0));
        directed("unf_edge",    mkop(0, 0, 1, 1023, 0, 0, 0),    rv(0, 0, 0, 0, 1, 0, 1, 0));
        directed("div_by_zero", mkop(0, 1, 1023, 0, 0, 0, 1),    rv(2047, 1, 0, 1, 0, 0, 0, 1));
        directed("zero_zero",   mkop(0, 0, 0, 0, 0, 0, 1),       rv(2047, 0, 1, 0, 0, 0, 0, 0));
        directed("inf_inf",     mkop(1, 0, 2047, 2047, 0, 0, 1), rv(2047, 1, 1, 0, 0, 0, 0, 0));
        directed("zero_nan",    mkop(0, 0, 0, 2047, 0, 1, 1),    rv(2047, 0, 1, 0, 0, 0, 0, 0));
        directed("five_inf",    mkop(0, 1, 5, 2047, 0, 0, 1),    rv(0, 1, 0, 0, 1, 0, 0, 0));
        directed("inf_zero",    mkop(0, 0, 2047, 0, 0, 0, 1),    rv(2047, 0, 0, 1, 0, 0, 0, 0));
        directed("inf_norm",    mkop(1, 1, 2047, 500, 0, 1, 0),  rv(2047, 0, 0, 1, 0, 0, 0, 0));

        sent = 0; recv = 0;
        for (int cyc = 0; cyc < 20 && recv < 4; cyc++) begin
            out_ready = (cyc >= 6);
            if (sent < 4) begin
                apply(mkop(0, 0, 1000 + sent, 1023, 0, 0, 1));
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc < 6) check("bp_in_ready", 32'(in_ready), (cyc < 2) ? 32'd1 : 32'd0);
            if (cyc >= 6) begin
                check("bp_consecutive", 32'(out_valid), 32'd1);
                if (out_valid) begin
                    check("bp_order", 32'(exp_out), 32'(1000 + recv));
                    recv++;
                end
            end
            if (in_valid && in_ready) sent++;
            tick();
        end
        in_valid = 1'b0;
        check("bp_count", 32'(recv), 32'd4);

        out_ready = 1'b0;
        apply(mkop(0, 0, 1023, 1023, 0, 0, 1));
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        check("rst_pre_valid", 32'(out_valid), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("rst_async_valid", 32'(out_valid), 32'd0);
        check("rst_async_payload", 32'(obs), 32'd0);
        check("rst_async_in_ready", 32'(in_ready), 32'd1);
        #2 rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("rst_no_stale", 32'(out_valid), 32'd0);
            tick();
        end
        directed("rst_after", mkop(0, 0, 1023, 1023, 0, 0, 1), rv(1023, 0, 0, 0, 0, 0, 0, 0));

        sent = 0; recv = 0; holding = 1'b0; cur = '0;
        for (int cyc = 0; cyc < 4000 && recv < 300; cyc++) begin
            if (!holding) begin
                if (sent < 300 && $urandom_range(0, 3) != 0) begin
                    cur = randop();
                    apply(cur);
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            if (fire_out) begin
                if (q.size() == 0) begin
                    check("rand_spurious", 32'(out_valid), 32'd0);
                end else begin
                    check("rand_result", 32'(obs), 32'(q.pop_front()));
                end
                recv++;
            end
            if (fire_in) begin
                q.push_back(model(cur));
                sent++;
                holding = 1'b0;
            end else begin
                holding = in_valid;
            end
            tick();
        end
        in_valid = 1'b0;
        check("rand_count", 32'(recv), 32'd300);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/dp_exp_divide.md
# dp_exp_divide

Pipelined exponent and special-case unit for the double-precision divider. It is the division counterpart of the multiplier's exponent path, which forms a+b-1023: this block forms a-b+1023 with a mantissa-normalisation correction. It classifies operands, saturates to overflow or underflow, and produces the result sign. It sits between the operand unpacker and the mantissa divider/packer, behind a two-stage valid/ready pipeline.

## Interface
- No parameters. Widths are fixed by IEEE-754 binary64.
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand set present
- in_ready  output  1  block accepts the operand set this cycle
- a_sign, b_sign  input  1 each  operand signs (dividend a, divisor b)
- a_exp, b_exp  input  11 each  biased exponents
- a_man_nz, b_man_nz  input  1 each  fraction field nonzero
- sig_ge  input  1  1 when significand(a) ≥ significand(b), so the quotient needs no left shift
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts the result
- exp_out  output  11  biased result exponent
- sign_out  output  1  a_sign ^ b_sign, also valid for specials
- is_nan, is_inf, is_zero  output  1 each  result class
- ovf, unf, dbz  output  1 each  overflow, underflow, divide-by-zero flags

## Operation
- Operand classes:
  - exp = 0 → zero. Subnormals are flushed, so mantissa is ignored.
  - exp = 2047 with man_nz → NaN.
  - exp = 2047 with !man_nz → inf.
  - Anything else → normal.
- Result class priority, evaluated top to bottom:
  1. NaN if a NaN, b NaN, a zero and b zero, or a inf and b inf.
  2. Inf if a inf or b zero. dbz = 1 only when b is zero and a is normal.
  3. Zero if a zero or b inf.
  4. Otherwise normal.
- Normal path:
  - e = a_exp − b_exp + 1023 − (sig_ge ? 0 : 1), computed as 13-bit two's complement. The range is −1023..3068, so it never wraps.
  - e ≥ 2047 → ovf = 1, is_inf = 1, exp_out = 2047.
  - e ≤ 0 → unf = 1, is_zero = 1, exp_out = 0.
  - Otherwise exp_out = e[10:0].
- exp_out for specials: NaN → 2047, inf → 2047, zero → 0.
- Flags are mutually consistent:
  - Exactly one of is_nan / is_inf / is_zero / normal holds.
  - ovf implies is_inf.
  - unf implies is_zero.
  - ovf, unf and dbz are never set for a NaN result.
- Stage 1 (S1) registers the operands, classification and the 13-bit e.
- Stage 2 (S2) registers saturation, flags and the final outputs.

## Timing
- Latency is 2 cycles: an operand accepted at edge N appears with out_valid at edge N+2 if it is not stalled.
- Throughput is 1 result per cycle while out_ready = 1.
- Handshake:
  - A transfer happens on an edge where valid && ready.
  - The producer must hold the payload stable while valid && !ready.
  - out_valid and all outputs hold stable until out_ready.
- Advance rules:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv, which is combinational from out_ready and the stage valids.
- Capacity is 2 in flight. With out_ready held low, in_ready drops once both stages are full.
- Results leave in order, with no loss or duplication.
- A bubble (in_valid = 0) with S1 advancing clears s1_valid.
- Reset, applied asynchronously at any time including mid-stall:
  - s1_valid, s2_valid and out_valid go to 0.
  - exp_out, sign_out and all flags go to 0.
  - In-flight operands are discarded.
  - in_ready is 1 on the first cycle after rst_n rises.
- Payload registers of an empty stage are don't-care internally, but the outputs must read 0 until the first result.

## Test plan
- 1.0/1.0:
  - Stimulus: a_exp = b_exp = 1023, sig_ge = 1, man_nz = 0, signs 0/1.
  - Required: two cycles later exp_out = 1023, sign_out = 1, all flags 0.
- Normalisation correction:
  - Stimulus: a_exp = 1023, b_exp = 1023, sig_ge = 0.
  - Required: exp_out = 1022.
- Boundary:
  - Stimulus: a_exp = 2046, b_exp = 1, sig_ge = 1.
  - Required: ovf = 1, is_inf = 1, exp_out = 2047.
  - Stimulus: a_exp = 1, b_exp = 2046, sig_ge = 1.
  - Required: unf = 1, is_zero = 1, exp_out = 0.
  - Stimulus: a_exp = 1024, b_exp = 1, sig_ge = 0.
  - Required: e = 2045, exp_out = 2045, no flags.
- Specials:
  - Stimulus: b_exp = 0, a_exp = 1023.
  - Required: is_inf = 1, dbz = 1, exp_out = 2047.
  - Stimulus: a = 0, b = 0.
  - Required: is_nan = 1, dbz = 0.
  - Stimulus: a inf, b inf.
  - Required: is_nan = 1.
  - Stimulus: a = 0, b NaN.
  - Required: is_nan = 1.
  - Stimulus: a = 5, b inf.
  - Required: is_zero = 1, unf = 0.
- Backpressure:
  - Stimulus: in_valid = 1 every cycle with exponents 1000, 1001, 1002, 1003, b_exp = 1023, sig_ge = 1, while out_ready = 0 for cycles 0–5.
  - Required: in_ready = 0 from cycle 2 while the stall holds.
  - Required: after out_ready rises, outputs are 1000, 1001, 1002, 1003 in order on consecutive cycles.
- Reset mid-operation:
  - Stimulus: assert rst_n = 0 asynchronously between edges while 2 results are in flight.
  - Required: out_valid and all flags drop to 0 immediately.
  - Required: after release, no stale result appears, and a new 1023/1023 operand yields 1023 at latency 2.
